// File: rtl/sp_ram_rr_arbiter.sv
// Purpose: round-robin share of one byte-write, read-first single-port RAM between two requesters.
// Latency: request fires to the RAM in the accept cycle, response valid the next cycle (1 cycle).
// Backpressure: one access in flight; new requests stall until the pending response is taken.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mN_req_valid/ready/addr/wen/wdata   request channel of requester N (wen==0 -> read)
//   mN_resp_valid/ready/rdata          response channel of requester N (old word, read-first)
//   ram_en/wen/addr/din/dout           RAM macro interface (dout valid 1 cycle after en, held while en=0)
module sp_ram_rr_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 128,
    parameter int COL_WIDTH  = 8,
    parameter int NUM_COL    = DATA_WIDTH / COL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [NUM_COL-1:0]    m0_req_wen,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_resp_valid,
    input  logic                  m0_resp_ready,
    output logic [DATA_WIDTH-1:0] m0_resp_rdata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [NUM_COL-1:0]    m1_req_wen,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_resp_valid,
    input  logic                  m1_resp_ready,
    output logic [DATA_WIDTH-1:0] m1_resp_rdata,

    output logic                  ram_en,
    output logic [NUM_COL-1:0]    ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;

    logic   resp_hs;
    logic   free;
    logic   gnt_vld;
    logic   gnt;
    logic   fire;

    always_comb begin
        // Response side: only the owner sees a valid response while BUSY.
        m0_resp_valid = ~rst & (state_q == BUSY) & ~owner_q;
        m1_resp_valid = ~rst & (state_q == BUSY) &  owner_q;
        // RAM holds dout while en=0, so both requesters can simply see it.
        m0_resp_rdata = ram_dout;
        m1_resp_rdata = ram_dout;

        // Other requester's resp_ready is masked out by its resp_valid being 0.
        resp_hs = (m0_resp_valid & m0_resp_ready) | (m1_resp_valid & m1_resp_ready);
        free    = (state_q == IDLE) | resp_hs;

        // Round-robin: on a tie the requester that was not served last wins.
        gnt_vld = m0_req_valid | m1_req_valid;
        if (m0_req_valid & m1_req_valid) begin
            gnt = ~last_grant_q;
        end else begin
            gnt = m1_req_valid;
        end

        fire         = ~rst & free & gnt_vld;
        m0_req_ready = ~rst & free & gnt_vld & ~gnt;
        m1_req_ready = ~rst & free & gnt_vld &  gnt;

        ram_en   = fire;
        ram_addr = gnt ? m1_req_addr  : m0_req_addr;
        ram_din  = gnt ? m1_req_wdata : m0_req_wdata;
        ram_wen  = '0;
        if (fire) begin
            ram_wen = gnt ? m1_req_wen : m0_req_wen;
        end

        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        if (fire) begin
            // Covers both a fresh access from IDLE and a back-to-back access
            // issued in the same cycle the previous response is taken.
            state_d      = BUSY;
            owner_d      = gnt;
            last_grant_d = gnt;
        end else if (resp_hs) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_sp_ram_rr_arbiter.sv
// Purpose: randomized + directed bench for sp_ram_rr_arbiter against a transaction-level model.
// Latency: model expects each accepted request's response one cycle later, held until taken.
// Backpressure: requesters hold request fields while valid and not accepted; resp_ready randomized.
module tb_sp_ram_rr_arbiter;

    localparam int AW = 8;
    localparam int DW = 128;
    localparam int NC = DW / 8;

    typedef struct {
        bit          who;
        logic [DW-1:0] data;
    } pend_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    rv, rdy, rsv, rsp_rdy;
    logic [AW-1:0] ra [2];
    logic [NC-1:0] rw [2];
    logic [DW-1:0] rd [2];
    logic [DW-1:0] rs_dat [2];
    logic          ram_en;
    logic [NC-1:0] ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] ref_mem [256];
    pend_t         pend_q[$];
    bit            last_who;
    bit   [1:0]    fired;
    int            n_checks = 0;
    int            n_err = 0;

    // snapshot of the last checked cycle, for directed spot checks
    logic          s_en;
    logic [1:0]    s_rdy, s_rsv;
    logic [DW-1:0] s_rd0, s_rd1;

    always #5 clk = ~clk;

    sp_ram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COL_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req_valid  (rv[0]),
        .m0_req_ready  (rdy[0]),
        .m0_req_addr   (ra[0]),
        .m0_req_wen    (rw[0]),
        .m0_req_wdata  (rd[0]),
        .m0_resp_valid (rsv[0]),
        .m0_resp_ready (rsp_rdy[0]),
        .m0_resp_rdata (rs_dat[0]),
        .m1_req_valid  (rv[1]),
        .m1_req_ready  (rdy[1]),
        .m1_req_addr   (ra[1]),
        .m1_req_wen    (rw[1]),
        .m1_req_wdata  (rd[1]),
        .m1_resp_valid (rsv[1]),
        .m1_resp_ready (rsp_rdy[1]),
        .m1_resp_rdata (rs_dat[1]),
        .ram_en        (ram_en),
        .ram_wen       (ram_wen),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout)
    );

    // Behavioural RAM macro: read-first, byte writes, dout held while en=0.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= ram_mem[ram_addr];
            for (int b = 0; b < NC; b++) begin
                if (ram_wen[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: check all outputs at negedge against the model, then advance the model.
    task automatic step();
        bit [1:0]      exp_rdy;
        bit [1:0]      exp_rsv;
        bit            free;
        bit            g_vld;
        bit            g;
        pend_t         p;
        @(negedge clk);
        exp_rdy = '0;
        exp_rsv = '0;
        g_vld   = 1'b0;
        g       = 1'b0;
        if (!rst) begin
            if (pend_q.size() != 0) exp_rsv[pend_q[0].who] = 1'b1;
            free = (pend_q.size() == 0) || rsp_rdy[pend_q[0].who];
            if (rv == 2'b11) begin
                g_vld = 1'b1;
                g = ~last_who;      // the one not served most recently
            end else if (rv != 2'b00) begin
                g_vld = 1'b1;
                g = rv[1];
            end
            if (free && g_vld) exp_rdy[g] = 1'b1;
        end
        fired = exp_rdy & rv;

        chk("req_ready", DW'(rdy), DW'(exp_rdy));
        chk("resp_valid", DW'(rsv), DW'(exp_rsv));
        chk("ram_en", DW'(ram_en), DW'(fired != 0));
        for (int n = 0; n < 2; n++) begin
            if (exp_rsv[n]) chk(n == 0 ? "m0_rdata" : "m1_rdata", rs_dat[n], pend_q[0].data);
        end
        if (fired != 0) begin
            chk("ram_addr", DW'(ram_addr), DW'(ra[g]));
            chk("ram_wen", DW'(ram_wen), DW'(rw[g]));
            if (rw[g] != 0) chk("ram_din", ram_din, rd[g]);
        end else begin
            chk("ram_wen_idle", DW'(ram_wen), '0);
        end

        s_en = ram_en; s_rdy = rdy; s_rsv = rsv; s_rd0 = rs_dat[0]; s_rd1 = rs_dat[1];

        if (rst) begin
            pend_q.delete();
            last_who = 1'b1;
        end else begin
            if (pend_q.size() != 0 && rsp_rdy[pend_q[0].who]) void'(pend_q.pop_front());
            if (fired != 0) begin
                p.who  = g;
                p.data = ref_mem[ra[g]];
                for (int b = 0; b < NC; b++) begin
                    if (rw[g][b]) ref_mem[ra[g]][b*8 +: 8] = rd[g][b*8 +: 8];
                end
                pend_q.push_back(p);
                last_who = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [AW-1:0] a,
                           input logic [NC-1:0] w, input logic [DW-1:0] d);
        rv[n] = v; ra[n] = a; rw[n] = w; rd[n] = d;
    endtask

    initial begin
        logic [DW-1:0] exp_word;
        int            alt_ok;
        for (int a = 0; a < 256; a++) begin
            ram_mem[a] = '0;
            ref_mem[a] = '0;
        end
        ram_mem[8'h10] = {NC{8'hA5}};
        ref_mem[8'h10] = {NC{8'hA5}};
        ram_dout = '0;
        last_who = 1'b1;
        fired    = '0;
        rst      = 1'b1;
        rsp_rdy  = 2'b11;
        set_req(0, 1'b1, 8'h20, '0, '0);
        set_req(1, 1'b1, 8'h21, '0, '0);

        // Reset with both requesters valid: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_quiet", DW'({s_en, s_rdy, s_rsv}), '0);
        end
        rst = 1'b0;

        // Contention: first tie goes to m0, then strict alternation.
        alt_ok = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("contend_grant", DW'(s_rdy), DW'((i % 2 == 0) ? 2'b01 : 2'b10));
            chk("contend_en", DW'(s_en), DW'(1));
        end
        rv = 2'b00;
        step();
        step();

        // Single read of the preloaded word.
        set_req(0, 1'b1, 8'h10, '0, '0);
        step();
        rv[0] = 1'b0;
        step();
        chk("read_a5", s_rd0, {NC{8'hA5}});
        chk("read_m1_quiet", DW'(s_rsv[1]), '0);

        // Byte write by m1 then m0 reads the merged word back.
        set_req(1, 1'b1, 8'h03, 16'h0001, {DW{1'b1}});
        step();
        rv[1] = 1'b0;
        set_req(0, 1'b1, 8'h03, '0, '0);
        step();
        chk("write_old", s_rd1, '0);
        rv[0] = 1'b0;
        step();
        exp_word = '0;
        exp_word[7:0] = 8'hFF;
        chk("write_merge", s_rd0, exp_word);

        // Backpressure: m0 holds its response, m1 waits, then fires on release.
        set_req(0, 1'b1, 8'h10, '0, '0);
        rsp_rdy[0] = 1'b0;
        step();
        rv[0] = 1'b0;
        set_req(1, 1'b1, 8'h05, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_stall", DW'({s_en, s_rdy}), '0);
            chk("bp_hold", s_rd0, {NC{8'hA5}});
        end
        rsp_rdy[0] = 1'b1;
        step();
        chk("bp_release", DW'({s_en, s_rdy}), DW'(3'b110));
        rv[1] = 1'b0;
        step();

        // Reset while m1's response is pending.
        rsp_rdy = 2'b00;
        set_req(1, 1'b1, 8'h07, '0, '0);
        step();
        rv[1] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_rdy = 2'b11;
        step();
        chk("rst_busy_drop", DW'(s_rsv), '0);
        rv = 2'b11;
        step();
        chk("rst_busy_tie_m0", DW'(s_rdy), DW'(2'b01));
        rv = 2'b00;
        step();
        step();

        // Randomized traffic with occasional reset.
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!rv[n] || fired[n]) begin
                    rv[n] = ($urandom_range(0, 99) < 60);
                    ra[n] = AW'($urandom_range(0, 15));
                    rw[n] = ($urandom_range(0, 1) == 0) ? '0 : NC'($urandom);
                    rd[n] = {$urandom, $urandom, $urandom, $urandom};
                end
                rsp_rdy[n] = ($urandom_range(0, 99) < 70);
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
